// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares one external SRAM between the Z80 CPU and the video fetch unit. The
// design runs in a single clock domain (clk28). Each access is a fixed-length
// SRAM cycle of ACC_CYC clocks. The CPU is stalled through cpu_wait until its
// request has been served.
//
// Optional feature macro: SRAM_ARB_FAIR_EN
//    defined   - a CPU request that is waiting is granted when a VID access
//                ends, even if vid_req is still high. This bounds CPU latency.
//    undefined - video has strict priority, so continuous video traffic can
//                starve the CPU.
//
// Parameters
//    RA_W     SRAM address width
//    ACC_CYC  clk28 cycles per SRAM access (minimum 2)
//
// Ports
//    clk28, rst_n            clock, asynchronous active-low reset
//    vid_req/vid_addr        video fetch request (level) and address
//    vid_ack                 one-cycle pulse in the first cycle of a video grant
//    vid_valid/vid_data      one-cycle valid pulse; read data is held afterwards
//    cpu_memreq/rd/wr        CPU bus strobes
//    cpu_ra                  mapped CPU physical address
//    cpu_din/cpu_dout        CPU write data; read data is held afterwards
//    cpu_wait                combinational CPU stall
//    sram_a, sram_dq_*       SRAM address and data bus
//    sram_oe_n, sram_we_n    SRAM strobes
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int RA_W    = 19,
   parameter int ACC_CYC = 2
) (
   input  logic            clk28,
   input  logic            rst_n,
   input  logic            vid_req,
   input  logic [RA_W-1:0] vid_addr,
   output logic            vid_ack,
   output logic            vid_valid,
   output logic [7:0]      vid_data,
   input  logic            cpu_memreq,
   input  logic            cpu_rd,
   input  logic            cpu_wr,
   input  logic [RA_W-1:0] cpu_ra,
   input  logic [7:0]      cpu_din,
   output logic [7:0]      cpu_dout,
   output logic            cpu_wait,
   output logic [RA_W-1:0] sram_a,
   output logic [7:0]      sram_dq_out,
   output logic            sram_dq_oe,
   input  logic [7:0]      sram_dq_in,
   output logic            sram_oe_n,
   output logic            sram_we_n
);

   localparam int CNT_W = (ACC_CYC > 2) ? $clog2(ACC_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

   typedef enum logic [1:0] {IDLE, VID, CPU_RD, CPU_WR} state_t;

   state_t           r_state, w_nextState;
   logic [CNT_W-1:0] r_cnt, w_nextCnt;
   logic             r_served;
   logic [RA_W-1:0]  r_sramA;
   logic [7:0]       r_dqOut, r_vidData, r_cpuDout;
   logic             r_dqOe, r_oeN, r_weN, r_vidAck, r_vidValid;

   logic w_inCpu, w_cpuPend, w_cpuReq, w_arb, w_vidEnd, w_cpuEnd;
   logic w_cpuFirst, w_grantVid, w_grantCpu;

   // Request and arbitration-point decode. A CPU request that is currently
   // being served does not count as a request at its own final cycle. This
   // keeps the access from being granted a second time.
   assign w_inCpu   = (r_state == CPU_RD) || (r_state == CPU_WR);
   assign w_cpuPend = cpu_memreq & (cpu_rd | cpu_wr) & ~r_served;
   assign w_cpuReq  = w_cpuPend & ~w_inCpu;
   assign w_arb     = (r_state == IDLE) || (r_cnt == '0);
   assign w_vidEnd  = (r_state == VID) && (r_cnt == '0);
   assign w_cpuEnd  = w_inCpu && (r_cnt == '0);
   assign cpu_wait  = w_cpuPend | w_inCpu;

`ifdef SRAM_ARB_FAIR_EN
   assign w_cpuFirst = w_vidEnd & w_cpuReq;
`else
   assign w_cpuFirst = 1'b0;
`endif

   // Next-state logic. A grant can only happen at an arbitration point, and
   // it reloads the access timer. Otherwise the timer counts down.
   always_comb begin
      w_grantVid  = 1'b0;
      w_grantCpu  = 1'b0;
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      if (w_arb) begin
         if (w_cpuFirst) begin
            w_grantCpu = 1'b1;
         end else if (vid_req) begin
            w_grantVid = 1'b1;
         end else if (w_cpuReq) begin
            w_grantCpu = 1'b1;
         end
         if (w_grantVid) begin
            w_nextState = VID;
         end else if (w_grantCpu) begin
            w_nextState = cpu_rd ? CPU_RD : CPU_WR;
         end else begin
            w_nextState = IDLE;
         end
         w_nextCnt = (w_grantVid || w_grantCpu) ? CNT_LOAD : '0;
      end else begin
         w_nextCnt = r_cnt - 1'b1;
      end
   end

   // State register and access timer.
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // The SRAM pins are registered from the next state so they are glitch-free.
   // Write enable is released in the final cycle so the data is held past the
   // rising edge of we_n.
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_sramA <= '0;
         r_dqOut <= 8'h00;
         r_dqOe  <= 1'b0;
         r_oeN   <= 1'b1;
         r_weN   <= 1'b1;
      end else begin
         if (w_grantVid) begin
            r_sramA <= vid_addr;
         end else if (w_grantCpu) begin
            r_sramA <= cpu_ra;
         end
         if (w_nextState == CPU_WR) begin
            r_dqOut <= cpu_din;
         end
         r_dqOe <= (w_nextState == CPU_WR);
         r_oeN  <= !((w_nextState == VID) || (w_nextState == CPU_RD));
         r_weN  <= !((w_nextState == CPU_WR) && (w_nextCnt != '0));
      end
   end

   // Read data is captured on the edge that ends an access. The served flag
   // allows only one access per memreq assertion, and it clears whenever
   // memreq is low.
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_vidAck   <= 1'b0;
         r_vidValid <= 1'b0;
         r_vidData  <= 8'hFF;
         r_cpuDout  <= 8'hFF;
         r_served   <= 1'b0;
      end else begin
         r_vidAck   <= w_grantVid;
         r_vidValid <= w_vidEnd;
         if (w_vidEnd) begin
            r_vidData <= sram_dq_in;
         end
         if (w_cpuEnd && (r_state == CPU_RD)) begin
            r_cpuDout <= sram_dq_in;
         end
         if (!cpu_memreq) begin
            r_served <= 1'b0;
         end else if (w_cpuEnd) begin
            r_served <= 1'b1;
         end
      end
   end

   assign vid_ack     = r_vidAck;
   assign vid_valid   = r_vidValid;
   assign vid_data    = r_vidData;
   assign cpu_dout    = r_cpuDout;
   assign sram_a      = r_sramA;
   assign sram_dq_out = r_dqOut;
   assign sram_dq_oe  = r_dqOe;
   assign sram_oe_n   = r_oeN;
   assign sram_we_n   = r_weN;

endmodule
